// File: rtl/sync_fifo_ext_if.sv
// Handshake and status bundle between a FIFO user (master) and sync_fifo_ext (slave).
interface sync_fifo_ext_if #(
  parameter int unsigned FIFO_DWIDTH = 64,
  parameter int unsigned FIFO_DEPTH  = 16
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                   flush;
  logic                   clr_err;
  logic                   wr_en;
  logic [FIFO_DWIDTH-1:0] wdata;
  logic                   rd_en;
  logic [FIFO_DWIDTH-1:0] rdata;
  logic                   rvalid;
  logic [CntW-1:0]        numel;
  logic                   empty;
  logic                   full;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output flush, clr_err, wr_en, wdata, rd_en,
    input  rdata, rvalid, numel, empty, full, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, wdata, rd_en,
    output rdata, rvalid, numel, empty, full, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with optional first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_ext #(
  parameter int unsigned FIFO_DWIDTH   = 64,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter bit          FWFT          = 1'b0,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_ext_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] AFullCnt  = CntW'(AFULL_THRESH);
  localparam logic [CntW-1:0] AEmptyCnt = CntW'(AEMPTY_THRESH);

  logic [FIFO_DWIDTH-1:0] mem [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] numel_q, numel_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic is_empty, is_full, rd_acc, wr_acc;

  assign is_empty = (numel_q == '0);
  assign is_full  = (numel_q == DepthCnt);

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign rd_acc = bus.rd_en & ~is_empty;
  assign wr_acc = bus.wr_en & (~is_full | rd_acc);

  assign bus.numel        = numel_q;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (numel_q >= AFullCnt);
  assign bus.almost_empty = (numel_q <= AEmptyCnt);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // Next-state for pointers, count and sticky errors; flush ignores requests.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    numel_d  = numel_q;
    // A set in the same cycle overrides the clear below.
    ovf_d    = ovf_q & ~bus.clr_err;
    udf_d    = udf_q & ~bus.clr_err;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      numel_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_acc && !rd_acc) begin
        numel_d = numel_q + 1'b1;
      end else if (!wr_acc && rd_acc) begin
        numel_d = numel_q - 1'b1;
      end
      if (bus.wr_en && !wr_acc) ovf_d = 1'b1;
      if (bus.rd_en && !rd_acc) udf_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      numel_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      numel_q  <= numel_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && wr_acc) begin
      mem[wr_ptr_q] <= bus.wdata;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally; zero while empty keeps the output quiet.
    assign bus.rdata  = is_empty ? '0 : mem[rd_ptr_q];
    assign bus.rvalid = ~is_empty;
  end else begin : g_std
    logic [FIFO_DWIDTH-1:0] rdata_q;
    logic                   rvalid_q;

    // Registered read: capture the head on an accepted pop, hold otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (bus.flush) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem[rd_ptr_q];
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench: one standard-read instance and one FWFT instance, both depth 16.
module tb_sync_fifo_ext;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;
  localparam int          AF    = 14;
  localparam int          AE    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_ext_if #(.FIFO_DWIDTH(DW), .FIFO_DEPTH(DEPTH)) bs ();
  sync_fifo_ext_if #(.FIFO_DWIDTH(DW), .FIFO_DEPTH(DEPTH)) bf ();

  sync_fifo_ext #(
    .FIFO_DWIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b0), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) u_std (
    .clk(clk),
    .rst(rst),
    .bus(bs.slave)
  );

  sync_fifo_ext #(
    .FIFO_DWIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1'b1), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) u_fwft (
    .clk(clk),
    .rst(rst),
    .bus(bf.slave)
  );

  typedef struct packed {
    logic        wr;
    logic [63:0] wd;
    logic        rd;
    logic        ce;
    logic [4:0]  numel;
    logic        rvalid;
    logic        chk_rd;
    logic [63:0] rdata;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t tbl [9];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the chosen instance (other idles), then sample 1ns after the edge.
  task automatic step(input bit f, input logic w, input logic [63:0] d, input logic r,
                      input logic fl, input logic ce);
    bs.wr_en = 1'b0; bs.wdata = '0; bs.rd_en = 1'b0; bs.flush = 1'b0; bs.clr_err = 1'b0;
    bf.wr_en = 1'b0; bf.wdata = '0; bf.rd_en = 1'b0; bf.flush = 1'b0; bf.clr_err = 1'b0;
    if (f) begin
      bf.wr_en = w; bf.wdata = d; bf.rd_en = r; bf.flush = fl; bf.clr_err = ce;
    end else begin
      bs.wr_en = w; bs.wdata = d; bs.rd_en = r; bs.flush = fl; bs.clr_err = ce;
    end
    @(posedge clk);
    #1;
  endtask

  // Count and every status flag of the standard instance against a stored count of n.
  task automatic chk_cnt(input string tag, input int n);
    chk({tag, ".numel"}, 64'(bs.numel), 64'(n));
    chk({tag, ".empty"}, 64'(bs.empty), 64'(n == 0));
    chk({tag, ".full"}, 64'(bs.full), 64'(n == DEPTH));
    chk({tag, ".afull"}, 64'(bs.almost_full), 64'(n >= AF));
    chk({tag, ".aempty"}, 64'(bs.almost_empty), 64'(n <= AE));
  endtask

  task automatic apply(input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    step(1'b0, tbl[idx].wr, tbl[idx].wd, tbl[idx].rd, 1'b0, tbl[idx].ce);
    chk({tag, ".numel"}, 64'(bs.numel), 64'(tbl[idx].numel));
    chk({tag, ".rvalid"}, 64'(bs.rvalid), 64'(tbl[idx].rvalid));
    if (tbl[idx].chk_rd) chk({tag, ".rdata"}, bs.rdata, tbl[idx].rdata);
    chk({tag, ".ovf"}, 64'(bs.overflow), 64'(tbl[idx].ovf));
    chk({tag, ".udf"}, 64'(bs.underflow), 64'(tbl[idx].udf));
  endtask

  initial begin
    //          wr  wd        rd  ce  numel rv  chkrd rdata     ovf udf
    tbl[0] = '{1'b1, 64'hAA, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 64'h0,   1'b1, 1'b0};
    tbl[1] = '{1'b1, 64'hBB, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 64'h101, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 64'h0,  1'b0, 1'b1, 5'd16, 1'b0, 1'b0, 64'h0,   1'b0, 1'b0};
    tbl[3] = '{1'b0, 64'h0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 64'h0,   1'b0, 1'b1};
    tbl[4] = '{1'b1, 64'h55, 1'b1, 1'b0, 5'd1,  1'b0, 1'b0, 64'h0,   1'b0, 1'b1};
    tbl[5] = '{1'b0, 64'h0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 64'h55,  1'b0, 1'b1};
    tbl[6] = '{1'b0, 64'h0,  1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 64'h55,  1'b0, 1'b0};
    tbl[7] = '{1'b0, 64'h0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 64'h0,   1'b0, 1'b1};
    tbl[8] = '{1'b0, 64'h0,  1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 64'h0,   1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_cnt("reset", 0);
    chk("reset.rvalid", 64'(bs.rvalid), 64'd0);
    chk("reset.rdata", bs.rdata, 64'd0);
    chk("reset.ovf", 64'(bs.overflow), 64'd0);
    chk("reset.udf", 64'(bs.underflow), 64'd0);
    chk("reset.fwft_rvalid", 64'(bf.rvalid), 64'd0);
    chk("reset.fwft_empty", 64'(bf.empty), 64'd1);

    // 1: fill and drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
      chk_cnt($sformatf("fill%0d", i), i);
      chk($sformatf("fill%0d.rvalid", i), 64'(bs.rvalid), 64'd0);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("drain%0d.rdata", i), bs.rdata, 64'(i));
      chk($sformatf("drain%0d.rvalid", i), 64'(bs.rvalid), 64'd1);
      chk_cnt($sformatf("drain%0d", i), 16 - i);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("drain_idle.rvalid", 64'(bs.rvalid), 64'd0);
    chk("drain_idle.rdata", bs.rdata, 64'h10);

    // 2: overflow, accept-on-full with pop, clear
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 64'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    chk_cnt("refill", 16);
    apply(0);
    apply(1);
    apply(2);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("ovdrain%0d.rdata", i), bs.rdata,
          (i < 15) ? 64'(32'h102 + i) : 64'hBB);
      chk_cnt($sformatf("ovdrain%0d", i), 15 - i);
    end

    // 3: underflow, push+pop on empty, set-wins-over-clear
    for (int i = 3; i <= 8; i++) apply(i);

    // 5: pointer wrap, then flush
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 64'(32'h180 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("pre%0d.rdata", i), bs.rdata, 64'(32'h180 + i));
    end
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 64'(32'h200 + i), 1'b0, 1'b0, 1'b0);
    chk_cnt("wrapfull", 16);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("wrap%0d.rdata", i), bs.rdata, 64'(32'h200 + i));
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("preflush.udf", 64'(bs.underflow), 64'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'(32'h250 + i), 1'b0, 1'b0, 1'b0);
    chk_cnt("preflush", 5);
    step(1'b0, 1'b1, 64'h999, 1'b1, 1'b1, 1'b0);
    chk_cnt("flush", 0);
    chk("flush.rvalid", 64'(bs.rvalid), 64'd0);
    chk("flush.rdata", bs.rdata, 64'h210);
    chk("flush.udf", 64'(bs.underflow), 64'd1);
    chk("flush.ovf", 64'(bs.overflow), 64'd0);
    step(1'b0, 1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
    chk_cnt("postflush", 1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("postflush.rdata", bs.rdata, 64'h77);

    // 6: reset mid-burst
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 64'(32'h300 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("prerst.rdata", bs.rdata, 64'h301);
    rst = 1'b1;
    step(1'b0, 1'b1, 64'h3FF, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    chk_cnt("midrst", 0);
    chk("midrst.rdata", bs.rdata, 64'd0);
    chk("midrst.rvalid", 64'(bs.rvalid), 64'd0);
    chk("midrst.ovf", 64'(bs.overflow), 64'd0);
    chk("midrst.udf", 64'(bs.underflow), 64'd0);

    // 4: FWFT instance
    step(1'b1, 1'b1, 64'hC0DE, 1'b0, 1'b0, 1'b0);
    chk("fw_push.rvalid", 64'(bf.rvalid), 64'd1);
    chk("fw_push.rdata", bf.rdata, 64'hC0DE);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("fw_hold.rdata", bf.rdata, 64'hC0DE);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fw_pop.rvalid", 64'(bf.rvalid), 64'd0);
    chk("fw_pop.empty", 64'(bf.empty), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 64'(32'hA0 + i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("fw_fill%0d.rdata", i), bf.rdata, 64'hA1);
      chk($sformatf("fw_fill%0d.numel", i), 64'(bf.numel), 64'(i));
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("fw_drain%0d.rvalid", i), 64'(bf.rvalid), 64'(i < 3));
      if (bf.rvalid) chk($sformatf("fw_drain%0d.rdata", i), bf.rdata, 64'(32'hA1 + i));
    end
    chk("fw_end.underflow", 64'(bf.underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
